// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the HEX digit decoders.
// Optional leading-zero blanking is enabled by defining BIN2BCD_LEADING_ZERO_BLANK_EN.
module bin2bcd_seq #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic [DIGITS-1:0]     digit_blank
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  // Double-dabble correction: every nibble of 5 or more gets 3 added before the shift.
  function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] r;
    r = acc;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = acc[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = acc[4*k +: 4];
      end
    end
    return r;
  endfunction

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  // Digit k is blanked when it and every digit above it are zero; digit 0 always shows.
  function automatic logic [DIGITS-1:0] lead_blank(input logic [ACC_W-1:0] v);
    logic [DIGITS-1:0] b;
    logic              zero_above;
    b          = {DIGITS{1'b0}};
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (v[4*k +: 4] == 4'd0);
      b[k]       = zero_above;
    end
    return b;
  endfunction

  logic [DIGITS-1:0] blank_q, blank_d;
`endif

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  shift_q, shift_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ACC_W-1:0]  bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic [ACC_W-1:0]  corr_s;
  logic [ACC_W-1:0]  next_acc_s;
  logic [63:0]       bin_ext_s;

  // Next-state and datapath for the IDLE/SHIFT sequencer.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    blank_d    = blank_q;
`endif
    corr_s     = add3(acc_q);
    next_acc_s = {corr_s[ACC_W-2:0], shift_q[BIN_W-1]};
    bin_ext_s  = 64'(bin_in);

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d    = bin_in;
          acc_d      = {ACC_W{1'b0}};
          cnt_d      = CNT_W'(BIN_W);
          ovf_pend_d = (bin_ext_s > MAX_VAL);
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d   = next_acc_s;
        shift_d = {shift_q[BIN_W-2:0], 1'b0};
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Overflowed inputs saturate to all nines instead of showing a wrapped value.
          if (ovf_pend_q) begin
            bcd_d = {DIGITS{4'h9}};
          end else begin
            bcd_d = next_acc_s;
          end
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
          if (ovf_pend_q) begin
            blank_d = {DIGITS{1'b0}};
          end else begin
            blank_d = lead_blank(next_acc_s);
          end
`endif
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= {BIN_W{1'b0}};
      acc_q      <= {ACC_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= {ACC_W{1'b0}};
      ovf_q      <= 1'b0;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
      blank_q    <= BLANK_RST;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
      blank_q    <= blank_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
  assign digit_blank = blank_q;
`else
  assign digit_blank = {DIGITS{1'b0}};
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (BIN_W=20, DIGITS=6).
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [19:0] bin_in;
  logic        busy;
  logic        done;
  logic [23:0] bcd_out;
  logic        ovf;
  logic [5:0]  digit_blank;

  int n_cmp;
  int n_err;

  bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bin_in      (bin_in),
    .busy        (busy),
    .done        (done),
    .bcd_out     (bcd_out),
    .ovf         (ovf),
    .digit_blank (digit_blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected blanking mask: the given pattern when the feature is built in, else zero.
  function automatic logic [5:0] eb(input logic [5:0] b);
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    return b;
`else
    return 6'b000000;
`endif
  endfunction

  // Issue one start pulse at a negedge and collect the result at the done pulse.
  task automatic run_conv(input logic [19:0] v, output int lat, output int busy_cnt,
                          output int stable, output logic [23:0] bcd, output logic o,
                          output logic [5:0] blk, output logic done_after);
    logic [23:0] prev;
    prev   = bcd_out;
    bin_in = v;
    start  = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    stable   = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (bcd_out !== prev) stable = 0;
      @(negedge clk);
      lat++;
    end
    bcd = bcd_out;
    o   = ovf;
    blk = digit_blank;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = 20'd0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (bcd_out !== 24'h000000) begin n_err++; $display("FAIL reset_bcd: got %h want 000000", bcd_out); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_cmp++; if (digit_blank !== eb(6'b111110)) begin n_err++; $display("FAIL reset_blank: got %b want %b", digit_blank, eb(6'b111110)); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc, st; logic [23:0] b; logic o; logic [5:0] bl; logic da;
    run_conv(20'd123456, lat, bc, st, b, o, bl, da);
    n_cmp++; if (lat !== 20) begin n_err++; $display("FAIL basic_latency: got %0d want 20", lat); end
    n_cmp++; if (bc !== 20) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 20", bc); end
    n_cmp++; if (st !== 1) begin n_err++; $display("FAIL basic_stable: bcd_out changed before done"); end
    n_cmp++; if (b !== 24'h123456) begin n_err++; $display("FAIL basic_bcd: got %h want 123456", b); end
    n_cmp++; if (o !== 1'b0) begin n_err++; $display("FAIL basic_ovf: got %b want 0", o); end
    n_cmp++; if (bl !== 6'b000000) begin n_err++; $display("FAIL basic_blank: got %b want 000000", bl); end
    n_cmp++; if (da !== 1'b0) begin n_err++; $display("FAIL basic_done_width: done still high next cycle"); end
  endtask

  task automatic test_range();
    int lat, bc, st; logic [23:0] b; logic o; logic [5:0] bl; logic da;
    run_conv(20'd0, lat, bc, st, b, o, bl, da);
    n_cmp++; if (b !== 24'h000000) begin n_err++; $display("FAIL zero_bcd: got %h want 000000", b); end
    n_cmp++; if (o !== 1'b0) begin n_err++; $display("FAIL zero_ovf: got %b want 0", o); end
    n_cmp++; if (bl !== eb(6'b111110)) begin n_err++; $display("FAIL zero_blank: got %b want %b", bl, eb(6'b111110)); end
    run_conv(20'd999999, lat, bc, st, b, o, bl, da);
    n_cmp++; if (b !== 24'h999999) begin n_err++; $display("FAIL max_bcd: got %h want 999999", b); end
    n_cmp++; if (o !== 1'b0) begin n_err++; $display("FAIL max_ovf: got %b want 0", o); end
    n_cmp++; if (lat !== 20) begin n_err++; $display("FAIL max_latency: got %0d want 20", lat); end
  endtask

  task automatic test_blank();
    int lat, bc, st; logic [23:0] b; logic o; logic [5:0] bl; logic da;
    run_conv(20'd42, lat, bc, st, b, o, bl, da);
    n_cmp++; if (b !== 24'h000042) begin n_err++; $display("FAIL blank42_bcd: got %h want 000042", b); end
    n_cmp++; if (bl !== eb(6'b111100)) begin n_err++; $display("FAIL blank42_mask: got %b want %b", bl, eb(6'b111100)); end
    run_conv(20'd1000, lat, bc, st, b, o, bl, da);
    n_cmp++; if (b !== 24'h001000) begin n_err++; $display("FAIL blank1000_bcd: got %h want 001000", b); end
    n_cmp++; if (bl !== eb(6'b110000)) begin n_err++; $display("FAIL blank1000_mask: got %b want %b", bl, eb(6'b110000)); end
    run_conv(20'd100000, lat, bc, st, b, o, bl, da);
    n_cmp++; if (b !== 24'h100000) begin n_err++; $display("FAIL blank100000_bcd: got %h want 100000", b); end
    n_cmp++; if (bl !== 6'b000000) begin n_err++; $display("FAIL blank100000_mask: got %b want 000000", bl); end
  endtask

  task automatic test_overflow();
    int lat, bc, st; logic [23:0] b; logic o; logic [5:0] bl; logic da;
    run_conv(20'd1000000, lat, bc, st, b, o, bl, da);
    n_cmp++; if (b !== 24'h999999) begin n_err++; $display("FAIL ovf1m_bcd: got %h want 999999", b); end
    n_cmp++; if (o !== 1'b1) begin n_err++; $display("FAIL ovf1m_flag: got %b want 1", o); end
    n_cmp++; if (bl !== 6'b000000) begin n_err++; $display("FAIL ovf1m_blank: got %b want 000000", bl); end
    run_conv(20'd1048575, lat, bc, st, b, o, bl, da);
    n_cmp++; if (b !== 24'h999999) begin n_err++; $display("FAIL ovfmax_bcd: got %h want 999999", b); end
    n_cmp++; if (o !== 1'b1) begin n_err++; $display("FAIL ovfmax_flag: got %b want 1", o); end
  endtask

  task automatic test_abort();
    int nd, lat, bc, st; logic [23:0] b; logic o; logic [5:0] bl; logic da;
    bin_in = 20'd123;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (bcd_out !== 24'h000000) begin n_err++; $display("FAIL abort_bcd: got %h want 000000", bcd_out); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL abort_ovf: got %b want 0", ovf); end
    n_cmp++; if (digit_blank !== eb(6'b111110)) begin n_err++; $display("FAIL abort_blank: got %b want %b", digit_blank, eb(6'b111110)); end
    @(negedge clk);
    rst = 1'b0;
    nd  = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", nd); end
    run_conv(20'd7, lat, bc, st, b, o, bl, da);
    n_cmp++; if (b !== 24'h000007) begin n_err++; $display("FAIL abort_next_bcd: got %h want 000007", b); end
    n_cmp++; if (lat !== 20) begin n_err++; $display("FAIL abort_next_latency: got %0d want 20", lat); end
    n_cmp++; if (bl !== eb(6'b111110)) begin n_err++; $display("FAIL abort_next_blank: got %b want %b", bl, eb(6'b111110)); end
  endtask

  task automatic test_ignore_start();
    int nd, first; logic [23:0] res;
    nd     = 0;
    first  = -1;
    res    = 24'h000000;
    bin_in = 20'd42;
    start  = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc == 5) begin
        start  = 1'b1;
        bin_in = 20'd777;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done === 1'b1) begin
        nd++;
        if (first < 0) begin
          first = cyc;
          res   = bcd_out;
        end
      end
    end
    n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
    n_cmp++; if (first !== 20) begin n_err++; $display("FAIL ignore_latency: got %0d want 20", first); end
    n_cmp++; if (res !== 24'h000042) begin n_err++; $display("FAIL ignore_bcd: got %h want 000042", res); end
  endtask

  task automatic test_back_to_back();
    int d1, d2; logic [23:0] v1, v2;
    d1 = -1; d2 = -1; v1 = 24'h0; v2 = 24'h0;
    bin_in = 20'd5;
    start  = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (d1 < 0) begin
          d1     = cyc;
          v1     = bcd_out;
          bin_in = 20'd99;
        end else if (d2 < 0) begin
          d2    = cyc;
          v2    = bcd_out;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    n_cmp++; if (d1 !== 20) begin n_err++; $display("FAIL b2b_first_latency: got %0d want 20", d1); end
    n_cmp++; if (v1 !== 24'h000005) begin n_err++; $display("FAIL b2b_first_bcd: got %h want 000005", v1); end
    n_cmp++; if (d2 !== 41) begin n_err++; $display("FAIL b2b_second_cycle: got %0d want 41", d2); end
    n_cmp++; if (v2 !== 24'h000099) begin n_err++; $display("FAIL b2b_second_bcd: got %h want 000099", v2); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_range();
    test_blank();
    test_overflow();
    test_abort();
    test_ignore_start();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Sits directly upstream of the per-digit 7-segment decoders on the HEX0..HEX5 displays.
- Converts a BIN_W-bit unsigned value into DIGITS packed 4-bit BCD nibbles, one nibble per decoder input.
- Holds the last result stable between conversions, so the displays never show intermediate values.

Parameters:
- BIN_W, 20: width of the binary input; one shift iteration per bit.
- DIGITS, 6: number of BCD digits produced; digit 0 is least significant (HEX0).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  conversion request; sampled only in IDLE.
- bin_in  input  BIN_W  unsigned value; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out/ovf update.
- bcd_out  output  4*DIGITS  packed BCD; nibble k in bits [4k+3:4k]; each nibble feeds one decoder's 4-bit input.
- ovf  output  1  captured value exceeded 10^DIGITS-1.
- digit_blank  output  DIGITS  per-digit blank request; top level forces that display to all-off (7'b1111111).

Behaviour:
- Reset (async, while rst=1): state=IDLE, busy=0, done=0, ovf=0, bcd_out=0, digit_blank=0 (with the feature enabled: {DIGITS-1{1'b1}},1'b0); internal shift and counter registers cleared.
- Assertion of rst mid-conversion aborts the conversion; no done pulse; outputs return to reset values.
- States: IDLE -> SHIFT -> IDLE.
- IDLE: on an edge with start=1:
  - capture bin_in into the shift register and clear the BCD accumulator;
  - iteration counter := BIN_W; ovf_pending := (bin_in > 10^DIGITS-1); state := SHIFT; busy := 1.
- SHIFT, each edge:
  - every accumulator nibble >= 5 has 3 added;
  - then the {accumulator, shift register} pair shifts left by 1 and the counter decrements.
- Final iteration (counter 1 -> 0), same edge:
  - bcd_out := corrected accumulator, or all nibbles 4'h9 if ovf_pending;
  - ovf := ovf_pending; done := 1 for exactly one cycle; busy := 0; state := IDLE.
- Latency: done is high in the cycle starting BIN_W edges after the accepting edge. Default 20 cycles; throughput one conversion per BIN_W+1 cycles.
- start=1 while busy is ignored, not queued. start held high continuously restarts a conversion in the cycle after done, capturing bin_in at that edge.
- bcd_out, ovf and digit_blank change only on the done edge; they are stable at all other times.
- Accumulator width: 4*DIGITS bits; bits shifted out of the top are discarded, since the overflow case is handled by saturation.
- Nibble values are always 0..9; codes 10..15 never appear on bcd_out.

Optional Feature:
- Macro: BIN2BCD_LEADING_ZERO_BLANK_EN.
- Defined:
  - on the done edge, digit_blank[k]=1 for every digit k above the most significant non-zero nibble;
  - digit 0 is never blanked (value 0 shows a single "0");
  - on overflow, digit_blank=0.
- Undefined: digit_blank is tied to all zeros.

Test Plan:
- start with bin_in=123456 -> done exactly 20 cycles after the accepting edge; bcd_out=24'h123456, ovf=0; busy high for those 20 cycles.
- bin_in=0, then bin_in=999999 -> bcd_out=24'h000000, then 24'h999999; ovf=0 both times.
- bin_in=1000000, then bin_in=1048575 -> bcd_out=24'h999999, ovf=1 both times.
- start pulse at cycle 5 of a conversion of 42 with bin_in=777 -> ignored; result 24'h000042; only one done pulse.
- rst asserted at cycle 10 of a conversion -> immediate reset values; no done; next start with 7 -> 24'h000007.
- Feature defined, bin_in=42 -> digit_blank=6'b111100. bin_in=0 -> 6'b111110. bin_in=1000000 -> 6'b000000. Feature undefined: always 6'b000000.
